// File: rtl/prng_pkg.sv
// Shared constants for the PRNG coefficient path: byte width, default
// buffer geometry and the pointer-width helper.
package prng_pkg;

  localparam int PRNG_BYTE_W   = 8;
  localparam int COEF_BITS_DEF = 5;
  localparam int DEPTH_DEF     = 8;

  // One extra MSB beyond the address bits separates full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/prng_done_edge.sv
// Rising-edge detector on the PRNG byte-complete flag, so that a level held
// high produces a single capture pulse.
module prng_done_edge (
  input  logic clk,
  input  logic res,
  input  logic level_i,
  output logic pulse_o
);

  logic prev_q;

  // Remember the previous level of the flag.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level_i;
    end
  end

  assign pulse_o = level_i & ~prev_q;

endmodule

// File: rtl/prng_coeff_buffer.sv
// Captures PRNG bytes flagged as coefficients into a small FIFO with a
// valid/ready output. Optional macro: PRNG_COEFF_ZERO_FILTER_EN drops zero coefficients.
module prng_coeff_buffer
  import prng_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int COEF_BITS = COEF_BITS_DEF
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic [PRNG_BYTE_W-1:0] din,
  input  logic                   din_done,
  output logic [COEF_BITS-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [COEF_BITS-1:0] mem_q [DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic                 overflow_q, overflow_d;
  logic                 cap_s, cap_ok_s, pop_s, full_s, wr_en_s;
  logic [COEF_BITS-1:0] coef_s;
  logic                 unused_din_s;

  prng_done_edge u_done_edge (
    .clk     (clk),
    .res     (res),
    .level_i (din_done),
    .pulse_o (cap_s)
  );

  assign coef_s       = din[COEF_BITS-1:0];
  assign unused_din_s = ^din;

`ifdef PRNG_COEFF_ZERO_FILTER_EN
  assign cap_ok_s = cap_s & (coef_s != {COEF_BITS{1'b0}});
`else
  assign cap_ok_s = cap_s;
`endif

  assign count     = wr_ptr_q - rd_ptr_q;
  assign out_valid = (count != {PW{1'b0}});
  assign full_s    = (count == PW'(DEPTH));
  assign pop_s     = out_valid & out_ready;
  assign out_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign overflow  = overflow_q;

  // Next-state pointers; a full FIFO still accepts a capture when the head pops.
  always_comb begin
    wr_en_s    = cap_ok_s & (~full_s | pop_s);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (cap_ok_s && full_s && !pop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Pointer and sticky overflow state.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Coefficient storage; contents are only meaningful behind valid pointers.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= coef_s;
    end
  end

endmodule

// File: tb/tb_prng_coeff_buffer.sv
// Scoreboard bench for prng_coeff_buffer: stimulus pushes hand-computed
// coefficients, a monitor checks every accepted output against them.
module tb_prng_coeff_buffer;

  logic       clk;
  logic       res;
  logic [7:0] din;
  logic       din_done;
  logic [4:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] count;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [4:0] exp_q [$];

  prng_coeff_buffer #(.DEPTH(8), .COEF_BITS(5)) dut (
    .clk       (clk),
    .res       (res),
    .din       (din),
    .din_done  (din_done),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output must match the head of the expected queue.
  always @(negedge clk) begin
    if (res && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%0h expected no data", out_data);
      end else begin
        chk("pop_data", int'(out_data), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] b);
    din      = b;
    din_done = 1'b1;
    step();
    din_done = 1'b0;
    step();
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) step();
    out_ready = 1'b0;
  endtask

  initial begin
    res       = 1'b0;
    din       = 8'h00;
    din_done  = 1'b0;
    out_ready = 1'b0;
    repeat (3) step();
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_overflow", int'(overflow), 0);
    res = 1'b1;

    // Single pulse: visible in the very next cycle
    din      = 8'hA7;
    din_done = 1'b1;
    step();
    din_done = 1'b0;
    chk("single_valid", int'(out_valid), 1);
    chk("single_data", int'(out_data), 'h07);
    chk("single_count", int'(count), 1);
    exp_q.push_back(5'h07);
    step();
    drain(1);
    chk("single_drained", int'(count), 0);

    // Fill, then simultaneous capture and pop while full
    for (int i = 1; i <= 8; i++) begin
      pulse(8'h40 + 8'(i));
      exp_q.push_back(5'(i));
    end
    chk("fill_count", int'(count), 8);
    din       = 8'h1F;
    din_done  = 1'b1;
    out_ready = 1'b1;
    step();
    din_done  = 1'b0;
    out_ready = 1'b0;
    exp_q.push_back(5'h1F);
    chk("simul_count", int'(count), 8);
    chk("simul_overflow", int'(overflow), 0);
    step();
    drain(8);
    chk("simul_drained", int'(count), 0);

    // Held flag captures exactly once
    din      = 8'h03;
    din_done = 1'b1;
    repeat (5) step();
    din_done = 1'b0;
    step();
    exp_q.push_back(5'h03);
    chk("held_count", int'(count), 1);
    drain(1);

    // Zero coefficient
    pulse(8'hE0);
`ifdef PRNG_COEFF_ZERO_FILTER_EN
    chk("zero_filtered_count", int'(count), 0);
`else
    chk("zero_kept_count", int'(count), 1);
    chk("zero_kept_data", int'(out_data), 0);
    exp_q.push_back(5'h00);
    drain(1);
`endif

    // Overflow: ninth byte dropped
    for (int i = 1; i <= 9; i++) begin
      pulse(8'(i));
      if (i <= 8) exp_q.push_back(5'(i));
    end
    chk("ovf_count", int'(count), 8);
    chk("ovf_flag", int'(overflow), 1);
    drain(8);
    chk("ovf_drained", int'(count), 0);
    chk("ovf_sticky", int'(overflow), 1);

    // Ready while empty is ignored
    drain(2);
    chk("ready_empty_count", int'(count), 0);

    // Asynchronous reset mid-stream with 5 entries held
    for (int i = 0; i < 5; i++) pulse(8'h10 + 8'(i));
    chk("pre_reset_count", int'(count), 5);
    #2;
    res = 1'b0;
    #1;
    chk("async_count", int'(count), 0);
    chk("async_valid", int'(out_valid), 0);
    chk("async_overflow", int'(overflow), 0);
    step();
    res = 1'b1;
    pulse(8'h5A);
    exp_q.push_back(5'h1A);
    chk("post_reset_count", int'(count), 1);
    drain(1);

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
